// File: rtl/ysyx_22050612_dmem_responder.sv
// Purpose : DEPTH x 64-bit data memory at BASE_ADDR serving one load/store at a time for the LSU.
// Latency : response valid LATENCY edges after the request is accepted (1..15), fixed per build.
// Backpr. : single outstanding request; req_ready low from accept until one cycle after rsp handshake.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   req_valid/req_ready            request handshake
//   req_wen/addr/wdata/wmask       1=store; byte address ([2:0] ignored); lane-aligned data; byte enables
//   rsp_valid/rsp_ready            response handshake
//   rsp_rdata/rsp_err              load word (0 for stores/errors); out-of-range or illegal mask
//
// Optional feature: define YSYX_22050612_DMEM_WMASK_CHECK_EN to reject store masks that are not a
// naturally aligned 1/2/4/8-byte lane group (rsp_err=1, no write). Without it every mask is written.
module ysyx_22050612_dmem_responder #(
    parameter int unsigned DEPTH     = 1024,
    parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
    parameter int unsigned LATENCY   = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [7:0]  req_wmask,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned AW     = $clog2(DEPTH);
    localparam logic [63:0] SPAN   = 64'(DEPTH) * 64'd8;
    localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);

    typedef struct packed {
        logic        wen;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wmask;
    } req_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q;
    req_t          req_q;
    req_t          req_in;
    req_t          cur;
    logic          accept;
    logic          commit;
    logic [63:0]   off;
    logic          in_range;
    logic          mask_legal;
    logic          err;
    logic [AW-1:0] idx;
    logic          do_write;
    logic [63:0]   rdata_q;
    logic          err_q;

    logic [63:0]   mem [DEPTH];

`ifdef YSYX_22050612_DMEM_WMASK_CHECK_EN
    // Naturally aligned 8/4/2/1-byte groups; an empty mask is a legal no-op.
    function automatic logic mask_ok(input logic [7:0] m);
        case (m)
            8'hFF, 8'h0F, 8'hF0,
            8'h03, 8'h0C, 8'h30, 8'hC0,
            8'h01, 8'h02, 8'h04, 8'h08,
            8'h10, 8'h20, 8'h40, 8'h80,
            8'h00:   mask_ok = 1'b1;
            default: mask_ok = 1'b0;
        endcase
    endfunction
`endif

    assign req_in = {req_wen, req_addr, req_wdata, req_wmask};
    assign accept = req_valid && req_ready;

    // With LATENCY==1 the access commits on the accept edge itself, before the
    // request has been latched, so the live inputs are used in IDLE.
    assign cur = (state_q == S_IDLE) ? req_in : req_q;

    assign off      = cur.addr - BASE_ADDR;
    assign in_range = (cur.addr >= BASE_ADDR) && (off < SPAN);
    assign idx      = off[AW+2:3];

`ifdef YSYX_22050612_DMEM_WMASK_CHECK_EN
    assign mask_legal = !cur.wen || mask_ok(cur.wmask);
`else
    assign mask_legal = 1'b1;
`endif

    assign err      = !in_range || !mask_legal;
    assign commit   = (state_d == S_RESP) && (state_q != S_RESP);
    assign do_write = commit && cur.wen && !err;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = (LATENCY == 1) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd1) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // req_ready is also forced low while reset is held, so nothing can be
    // accepted (or written) during the reset pulse.
    always_comb begin
        req_ready = (state_q == S_IDLE) && rst_n;
        rsp_valid = (state_q == S_RESP);
    end

    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    // ---------------- request latch, counter, response registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q   <= '0;
            cnt_q   <= 4'd0;
            rdata_q <= 64'd0;
            err_q   <= 1'b0;
        end else begin
            if ((state_q == S_IDLE) && accept) begin
                req_q <= req_in;
                cnt_q <= LAT_M1;
            end else if (state_q == S_WAIT) begin
                cnt_q <= cnt_q - 4'd1;
            end

            if (commit) begin
                err_q   <= err;
                rdata_q <= (!cur.wen && !err) ? mem[idx] : 64'd0;
            end else if ((state_q == S_RESP) && rsp_ready) begin
                err_q   <= 1'b0;
                rdata_q <= 64'd0;
            end
        end
    end

    // ---------------- storage (not reset) ----------------
    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int i = 0; i < 8; i++) begin
                if (cur.wmask[i]) begin
                    mem[idx][8*i +: 8] <= cur.wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_ysyx_22050612_dmem_responder.sv
module tb_ysyx_22050612_dmem_responder;

    logic        clk;
    logic        rst_n;
    logic        sel;          // 0 -> LATENCY=1 instance, 1 -> LATENCY=4 instance
    logic        req_valid;
    logic        rsp_ready;
    logic        req_wen;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_wmask;

    logic        req_valid_1, req_ready_1, rsp_valid_1, rsp_ready_1, rsp_err_1;
    logic        req_valid_4, req_ready_4, rsp_valid_4, rsp_ready_4, rsp_err_4;
    logic [63:0] rsp_rdata_1, rsp_rdata_4;

    logic        req_ready_m, rsp_valid_m, rsp_err_m;
    logic [63:0] rsp_rdata_m;

    int checks = 0;
    int errors = 0;

    assign req_valid_1 = req_valid & ~sel;
    assign req_valid_4 = req_valid & sel;
    assign rsp_ready_1 = rsp_ready & ~sel;
    assign rsp_ready_4 = rsp_ready & sel;

    assign req_ready_m = sel ? req_ready_4 : req_ready_1;
    assign rsp_valid_m = sel ? rsp_valid_4 : rsp_valid_1;
    assign rsp_err_m   = sel ? rsp_err_4   : rsp_err_1;
    assign rsp_rdata_m = sel ? rsp_rdata_4 : rsp_rdata_1;

    ysyx_22050612_dmem_responder #(
        .DEPTH(16), .BASE_ADDR(64'h8000_0000), .LATENCY(1)
    ) u_lat1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid_1), .req_ready(req_ready_1),
        .req_wen(req_wen), .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .rsp_valid(rsp_valid_1), .rsp_ready(rsp_ready_1),
        .rsp_rdata(rsp_rdata_1), .rsp_err(rsp_err_1)
    );

    ysyx_22050612_dmem_responder #(
        .DEPTH(16), .BASE_ADDR(64'h8000_0000), .LATENCY(4)
    ) u_lat4 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid_4), .req_ready(req_ready_4),
        .req_wen(req_wen), .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .rsp_valid(rsp_valid_4), .rsp_ready(rsp_ready_4),
        .rsp_rdata(rsp_rdata_4), .rsp_err(rsp_err_4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One full transaction: req_valid stays high through WAIT/RESP (must not be
    // re-accepted), response held for 'stall' cycles before rsp_ready.
    task automatic xact(input string tag, input logic s, input logic w,
                        input logic [63:0] a, input logic [63:0] d, input logic [7:0] m,
                        input int stall, input logic [63:0] exp_rd, input logic exp_er);
        int n;
        @(negedge clk);
        sel       = s;
        req_wen   = w;
        req_addr  = a;
        req_wdata = d;
        req_wmask = m;
        req_valid = 1'b1;
        chk({tag, ".req_ready"}, 64'(req_ready_m), 64'd1);
        @(negedge clk);
        n = 1;
        while (!rsp_valid_m && n < 32) begin
            chk({tag, ".busy_ready"}, 64'(req_ready_m), 64'd0);
            @(negedge clk);
            n++;
        end
        chk({tag, ".latency"}, 64'(n), s ? 64'd4 : 64'd1);
        for (int i = 0; i < stall; i++) begin
            chk({tag, ".stall_valid"}, 64'(rsp_valid_m), 64'd1);
            chk({tag, ".stall_rdata"}, rsp_rdata_m, exp_rd);
            chk({tag, ".stall_ready"}, 64'(req_ready_m), 64'd0);
            @(negedge clk);
        end
        chk({tag, ".valid"}, 64'(rsp_valid_m), 64'd1);
        chk({tag, ".rdata"}, rsp_rdata_m, exp_rd);
        chk({tag, ".err"}, 64'(rsp_err_m), 64'(exp_er));
        rsp_ready = 1'b1;
        req_valid = 1'b0;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({tag, ".post_valid"}, 64'(rsp_valid_m), 64'd0);
        chk({tag, ".post_rdata"}, rsp_rdata_m, 64'd0);
        chk({tag, ".post_err"}, 64'(rsp_err_m), 64'd0);
        chk({tag, ".post_ready"}, 64'(req_ready_m), 64'd1);
    endtask

    initial begin
        logic [63:0] exp_m_rd;
        logic        exp_m_er;

        rst_n     = 1'b0;
        sel       = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        req_wen   = 1'b0;
        req_addr  = 64'd0;
        req_wdata = 64'd0;
        req_wmask = 8'd0;
        repeat (2) @(negedge clk);

        // Reset state of both instances
        chk("rst.l1.req_ready", 64'(req_ready_1), 64'd0);
        chk("rst.l1.rsp_valid", 64'(rsp_valid_1), 64'd0);
        chk("rst.l1.rsp_rdata", rsp_rdata_1, 64'd0);
        chk("rst.l1.rsp_err",   64'(rsp_err_1), 64'd0);
        chk("rst.l4.req_ready", 64'(req_ready_4), 64'd0);
        chk("rst.l4.rsp_valid", 64'(rsp_valid_4), 64'd0);
        chk("rst.l4.rsp_rdata", rsp_rdata_4, 64'd0);
        chk("rst.l4.rsp_err",   64'(rsp_err_4), 64'd0);
        rst_n = 1'b1;

        // Full store then load, LATENCY=1
        xact("s1.st", 1'b0, 1'b1, 64'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF, 0, 64'd0, 1'b0);
        xact("s1.ld", 1'b0, 1'b0, 64'h8000_0010, 64'd0, 8'h00, 0, 64'h1122_3344_5566_7788, 1'b0);

        // Partial store, bytes 2 and 3
        xact("s2.st", 1'b0, 1'b1, 64'h8000_0010, 64'h0000_0000_AAAA_0000, 8'h0C, 0, 64'd0, 1'b0);
        xact("s2.ld", 1'b0, 1'b0, 64'h8000_0013, 64'd0, 8'h00, 0, 64'h1122_3344_AAAA_7788, 1'b0);

        // Empty mask store is a no-op without error
        xact("s2.st0", 1'b0, 1'b1, 64'h8000_0010, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 0, 64'd0, 1'b0);
        xact("s2.ld0", 1'b0, 1'b0, 64'h8000_0010, 64'd0, 8'h00, 0, 64'h1122_3344_AAAA_7788, 1'b0);

        // LATENCY=4 with a 3-cycle consumer stall
        xact("s3.st", 1'b1, 1'b1, 64'h8000_0008, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF, 0, 64'd0, 1'b0);
        xact("s3.ld", 1'b1, 1'b0, 64'h8000_0008, 64'd0, 8'h00, 3, 64'hDEAD_BEEF_CAFE_F00D, 1'b0);

        // Address range boundaries
        xact("s4.st0",  1'b0, 1'b1, 64'h8000_0000, 64'h0102_0304_0506_0708, 8'hFF, 0, 64'd0, 1'b0);
        xact("s4.lo",   1'b0, 1'b0, 64'h7FFF_FFF8, 64'd0, 8'h00, 0, 64'd0, 1'b1);
        xact("s4.hi",   1'b0, 1'b0, 64'h8000_0080, 64'd0, 8'h00, 0, 64'd0, 1'b1);
        xact("s4.sthi", 1'b0, 1'b1, 64'h8000_0080, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, 64'd0, 1'b1);
        xact("s4.ld0",  1'b0, 1'b0, 64'h8000_0000, 64'd0, 8'h00, 0, 64'h0102_0304_0506_0708, 1'b0);
        xact("s4.stl",  1'b0, 1'b1, 64'h8000_0078, 64'h0123_4567_89AB_CDEF, 8'hFF, 0, 64'd0, 1'b0);
        xact("s4.last", 1'b0, 1'b0, 64'h8000_0078, 64'd0, 8'h00, 0, 64'h0123_4567_89AB_CDEF, 1'b0);

        // Reset while a LATENCY=4 store is waiting: request dropped, no write
        @(negedge clk);
        sel       = 1'b1;
        req_wen   = 1'b1;
        req_addr  = 64'h8000_0008;
        req_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
        req_wmask = 8'hFF;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("s5.req_ready", 64'(req_ready_4), 64'd0);
        chk("s5.rsp_valid", 64'(rsp_valid_4), 64'd0);
        chk("s5.rsp_rdata", rsp_rdata_4, 64'd0);
        chk("s5.rsp_err",   64'(rsp_err_4), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("s5.idle_valid", 64'(rsp_valid_4), 64'd0);
        xact("s5.ld", 1'b1, 1'b0, 64'h8000_0008, 64'd0, 8'h00, 0, 64'hDEAD_BEEF_CAFE_F00D, 1'b0);

        // Irregular mask 0x11
`ifdef YSYX_22050612_DMEM_WMASK_CHECK_EN
        exp_m_rd = 64'd0;
        exp_m_er = 1'b1;
`else
        exp_m_rd = 64'h0000_00FF_0000_00FF;
        exp_m_er = 1'b0;
`endif
        xact("s6.clr", 1'b0, 1'b1, 64'h8000_0020, 64'd0, 8'hFF, 0, 64'd0, 1'b0);
        xact("s6.st",  1'b0, 1'b1, 64'h8000_0020, 64'hFFFF_FFFF_FFFF_FFFF, 8'h11, 0, 64'd0, exp_m_er);
        xact("s6.ld",  1'b0, 1'b0, 64'h8000_0020, 64'd0, 8'h00, 0, exp_m_rd, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
